// File: rtl/ar_br_cr_controlpath_pkg.sv
// Shared types and constants for the AR/BR/CR control FSM.
// Optional counters are enabled with the AR_BR_CR_OP_COUNT_EN macro.
package ar_br_cr_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        EVAL = 3'd2,
        DIV  = 3'd3,
        MUL  = 3'd4,
        CLR  = 3'd5,
        DONE = 3'd6
    } state_t;

    // {AR_neg, AR_pos, AR_zero} patterns accepted at EVAL
    localparam logic [2:0] FLAG_NEG  = 3'b100;
    localparam logic [2:0] FLAG_POS  = 3'b010;
    localparam logic [2:0] FLAG_ZERO = 3'b001;

    localparam int CNT_W_DEF = 8;

    localparam int OP_DIV = 0;
    localparam int OP_MUL = 1;
    localparam int OP_CLR = 2;

endpackage

// File: rtl/ar_br_cr_controlpath_if.sv
// Sequencer handshake, datapath status/strobes and operation counters.
interface ar_br_cr_controlpath_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             AR_neg;
    logic             AR_pos;
    logic             AR_zero;
    logic             load_AR_BR;
    logic             div_AR_T_CR;
    logic             mul_BR_T_CR;
    logic             clr_CR;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] cnt_div;
    logic [CNT_W-1:0] cnt_mul;
    logic [CNT_W-1:0] cnt_clr;

    modport master (
        output start, AR_neg, AR_pos, AR_zero,
        input  load_AR_BR, div_AR_T_CR, mul_BR_T_CR, clr_CR,
        input  busy, done, err, cnt_div, cnt_mul, cnt_clr
    );

    modport slave (
        input  start, AR_neg, AR_pos, AR_zero,
        output load_AR_BR, div_AR_T_CR, mul_BR_T_CR, clr_CR,
        output busy, done, err, cnt_div, cnt_mul, cnt_clr
    );
endinterface

// File: rtl/ar_br_cr_controlpath_sat_cnt.sv
// Unsigned up-counter that sticks at all-ones; cleared only by reset.
module ar_br_cr_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/ar_br_cr_controlpath.sv
// Control FSM for the AR/BR/CR datapath: load, evaluate AR status, one CR op, done handshake.
// Per-branch completion counters are built only when AR_BR_CR_OP_COUNT_EN is defined.
module ar_br_cr_controlpath
    import ar_br_cr_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    ar_br_cr_controlpath_if.slave bus
);
    state_t     state_q;
    state_t     state_d;
    logic       err_q;
    logic       err_d;
    logic [2:0] flags;

    assign flags = {bus.AR_neg, bus.AR_pos, bus.AR_zero};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    err_d   = 1'b0;
                end
            end
            LOAD: state_d = EVAL;
            EVAL: begin
                case (flags)
                    FLAG_NEG:  state_d = DIV;
                    FLAG_POS:  state_d = MUL;
                    FLAG_ZERO: state_d = CLR;
                    default: begin
                        // inconsistent status: take the harmless clear and flag it
                        state_d = CLR;
                        err_d   = 1'b1;
                    end
                endcase
            end
            DIV, MUL, CLR: state_d = DONE;
            DONE: begin
                if (!bus.start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.load_AR_BR  = 1'b0;
        bus.div_AR_T_CR = 1'b0;
        bus.mul_BR_T_CR = 1'b0;
        bus.clr_CR      = 1'b0;
        bus.done        = 1'b0;
        bus.busy        = (state_q != IDLE);
        case (state_q)
            LOAD:    bus.load_AR_BR  = 1'b1;
            DIV:     bus.div_AR_T_CR = 1'b1;
            MUL:     bus.mul_BR_T_CR = 1'b1;
            CLR:     bus.clr_CR      = 1'b1;
            DONE:    bus.done        = 1'b1;
            default: ;
        endcase
    end

    assign bus.err = err_q;

`ifdef AR_BR_CR_OP_COUNT_EN
    logic [2:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [3];

    assign cnt_inc[OP_DIV] = (state_q == DIV);
    assign cnt_inc[OP_MUL] = (state_q == MUL);
    assign cnt_inc[OP_CLR] = (state_q == CLR);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            ar_br_cr_sat_cnt #(
                .W(CNT_W)
            ) u_cnt (
                .clk    (clk),
                .reset  (reset),
                .inc    (cnt_inc[gi]),
                .count_o(cnt_val[gi])
            );
        end
    endgenerate

    assign bus.cnt_div = cnt_val[OP_DIV];
    assign bus.cnt_mul = cnt_val[OP_MUL];
    assign bus.cnt_clr = cnt_val[OP_CLR];
`else
    assign bus.cnt_div = {CNT_W{1'b0}};
    assign bus.cnt_mul = {CNT_W{1'b0}};
    assign bus.cnt_clr = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ar_br_cr_controlpath.sv
// Bench for ar_br_cr_controlpath: behavioural datapath, request-age model checked every cycle,
// plus directed requests with hand-computed timing, CR and counter values.
module tb_ar_br_cr_controlpath;
    localparam int CNT_W = ar_br_cr_pkg::CNT_W_DEF;
`ifdef AR_BR_CR_OP_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int K_DIV = 0;
    localparam int K_MUL = 1;
    localparam int K_CLR = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ar_br_cr_controlpath_if #(.CNT_W(CNT_W)) bus ();

    ar_br_cr_controlpath #(.CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Behavioural datapath driven by the DUT strobes
    logic [15:0] AR_data = '0;
    logic [15:0] BR_data = '0;
    logic [15:0] AR = '0;
    logic [15:0] BR = '0;
    logic [15:0] CR = '0;
    logic        force_en = 1'b0;
    logic [2:0]  force_val = 3'b000;
    logic [2:0]  real_flags;

    always @(posedge clk) begin
        if (bus.load_AR_BR) begin
            AR <= AR_data;
            BR <= BR_data;
        end else if (bus.div_AR_T_CR) begin
            CR <= $signed(AR) >>> 1;
        end else if (bus.mul_BR_T_CR) begin
            CR <= BR << 1;
        end else if (bus.clr_CR) begin
            CR <= 16'h0000;
        end
    end

    assign real_flags = {AR[15], (AR != 16'h0) && !AR[15], (AR == 16'h0)};
    assign {bus.AR_neg, bus.AR_pos, bus.AR_zero} = force_en ? force_val : real_flags;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int n);
        return CNT_ON ? ((n > CNT_MAX) ? CNT_MAX : n) : 0;
    endfunction

    // Model: a request is accepted when start is seen while not active; its age then
    // counts cycles (1 load, 2 evaluate, 3 operate, 4+ done until start seen low).
    bit m_valid = 1'b0;
    bit m_act   = 1'b0;
    int m_age   = 0;
    int m_op    = 0;
    bit m_err   = 1'b0;
    int m_cnt [3] = '{0, 0, 0};

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_act   = 1'b0;
            m_age   = 0;
            m_err   = 1'b0;
            m_cnt   = '{0, 0, 0};
        end else if (!m_act) begin
            if (bus.start) begin
                m_act = 1'b1;
                m_age = 1;
                m_err = 1'b0;
            end
        end else begin
            if (m_age == 2) begin
                if ($countones({bus.AR_neg, bus.AR_pos, bus.AR_zero}) != 1) begin
                    m_op  = K_CLR;
                    m_err = 1'b1;
                end else if (bus.AR_neg) m_op = K_DIV;
                else if (bus.AR_pos)     m_op = K_MUL;
                else                     m_op = K_CLR;
            end
            if (m_age == 3) m_cnt[m_op] = m_cnt[m_op] + 1;
            if (m_age >= 4 && !bus.start) begin
                m_act = 1'b0;
                m_age = 0;
            end else if (m_age < 4) begin
                m_age = m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_load", bus.load_AR_BR,  m_act && m_age == 1);
            chk("m_div",  bus.div_AR_T_CR, m_act && m_age == 3 && m_op == K_DIV);
            chk("m_mul",  bus.mul_BR_T_CR, m_act && m_age == 3 && m_op == K_MUL);
            chk("m_clr",  bus.clr_CR,      m_act && m_age == 3 && m_op == K_CLR);
            chk("m_busy", bus.busy,        m_act);
            chk("m_done", bus.done,        m_act && m_age >= 4);
            chk("m_err",  bus.err,         m_err);
            chk("m_cnt_div", 32'(bus.cnt_div), exp_cnt(m_cnt[K_DIV]));
            chk("m_cnt_mul", 32'(bus.cnt_mul), exp_cnt(m_cnt[K_MUL]));
            chk("m_cnt_clr", 32'(bus.cnt_clr), exp_cnt(m_cnt[K_CLR]));
            chk("m_excl", 32'($countones({bus.load_AR_BR, bus.div_AR_T_CR,
                                         bus.mul_BR_T_CR, bus.clr_CR})) <= 1, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] strobes();
        return {bus.load_AR_BR, bus.div_AR_T_CR, bus.mul_BR_T_CR, bus.clr_CR};
    endfunction

    // Pulsed request; checks the fixed N+1..N+5 timeline and returns in IDLE.
    task automatic req(input string name, input logic [15:0] a, input logic [15:0] b,
                       input int op, input logic exp_err);
        logic [3:0] want;
        want = (op == K_DIV) ? 4'b0100 : (op == K_MUL) ? 4'b0010 : 4'b0001;
        AR_data = a;
        BR_data = b;
        bus.start = 1'b1;
        tick();
        chk({name, "_load"}, strobes(), 4'b1000);
        chk({name, "_err_load"}, bus.err, 1'b0);
        bus.start = 1'b0;
        tick();
        chk({name, "_eval"}, strobes(), 4'b0000);
        tick();
        chk({name, "_op"}, strobes(), want);
        chk({name, "_err"}, bus.err, exp_err);
        tick();
        chk({name, "_done"}, bus.done, 1'b1);
        tick();
        chk({name, "_idle"}, {bus.busy, bus.done}, 2'b00);
        $display("txn %s: AR=%h BR=%h CR=%h err=%0b", name, a, b, CR, bus.err);
    endtask

    int loads;
    int ops;

    initial begin
        bus.start = 1'b0;
        repeat (3) tick();
        chk("rst_out", {strobes(), bus.busy, bus.done, bus.err}, 7'b0);
        chk("rst_cnt", {bus.cnt_div, bus.cnt_mul, bus.cnt_clr}, '0);
        reset = 1'b0;
        tick();

        req("div", 16'h8004, 16'h1111, K_DIV, 1'b0);
        chk("div_cr", CR, 16'hC002);
        chk("div_cnt", 32'(bus.cnt_div), exp_cnt(1));

        req("mul", 16'h0005, 16'h0003, K_MUL, 1'b0);
        chk("mul_cr", CR, 16'h0006);
        chk("mul_cnt", 32'(bus.cnt_mul), exp_cnt(1));

        req("clr", 16'h0000, 16'h0003, K_CLR, 1'b0);
        chk("clr_cr", CR, 16'h0000);
        chk("clr_cnt", 32'(bus.cnt_clr), exp_cnt(1));

        force_en  = 1'b1;
        force_val = 3'b101;
        req("illegal", 16'h0005, 16'h0003, K_CLR, 1'b1);
        force_en = 1'b0;
        chk("illegal_err_hold", bus.err, 1'b1);
        chk("illegal_cnt", 32'(bus.cnt_clr), exp_cnt(2));
        req("after_err", 16'h0005, 16'h0007, K_MUL, 1'b0);
        chk("after_err_cr", CR, 16'h000E);

        // reset landing in EVAL
        AR_data = 16'h8004;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("rstmid_eval", bus.busy, 1'b1);
        reset = 1'b1;
        tick();
        chk("rstmid_out", {strobes(), bus.busy, bus.done, bus.err}, 7'b0);
        chk("rstmid_cnt", {bus.cnt_div, bus.cnt_mul, bus.cnt_clr}, '0);
        tick();
        chk("rstmid_out2", strobes(), 4'b0000);
        reset = 1'b0;
        tick();
        $display("txn reset_mid: busy=%0b done=%0b", bus.busy, bus.done);

        // start held for 20 cycles
        AR_data = 16'h8004;
        bus.start = 1'b1;
        loads = 0;
        ops = 0;
        repeat (20) begin
            tick();
            loads += int'(bus.load_AR_BR);
            ops += int'(bus.div_AR_T_CR) + int'(bus.mul_BR_T_CR) + int'(bus.clr_CR);
        end
        chk("hold_loads", loads, 1);
        chk("hold_ops", ops, 1);
        chk("hold_done", bus.done, 1'b1);
        bus.start = 1'b0;
        tick();
        chk("hold_release", {bus.busy, bus.done}, 2'b00);
        chk("hold_cnt", 32'(bus.cnt_div), exp_cnt(1));
        $display("txn hold: loads=%0d ops=%0d", loads, ops);

        for (int i = 0; i < 300; i++) begin
            req("bulk_mul", 16'h0005, 16'h0003, K_MUL, 1'b0);
        end
        chk("sat_cnt_mul", 32'(bus.cnt_mul), CNT_ON ? 32'd255 : 32'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
